// File: rtl/db_pkg.sv
// Shared types for the debug access sequencer: FSM states, decoded commands
// and memory access size encodings.
package db_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HALT_WAIT   = 2'd1,
        ST_ACCESS      = 2'd2,
        ST_RESET_PULSE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_RESET  = 3'd1,
        CMD_MEM_WR = 3'd2,
        CMD_REG_WR = 3'd3,
        CMD_MEM_RD = 3'd4,
        CMD_REG_RD = 3'd5,
        CMD_PAUSE  = 3'd6,
        CMD_RESUME = 3'd7
    } cmd_t;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_INVALID = 2'd3;

    // Several flags may be set at once; the most disruptive command wins.
    function automatic cmd_t decode_cmd(input logic f_reset, input logic f_mem_wr,
                                        input logic f_reg_wr, input logic f_mem_rd,
                                        input logic f_reg_rd, input logic f_pause,
                                        input logic f_resume);
        cmd_t c;
        if (f_reset)       c = CMD_RESET;
        else if (f_mem_wr) c = CMD_MEM_WR;
        else if (f_reg_wr) c = CMD_REG_WR;
        else if (f_mem_rd) c = CMD_MEM_RD;
        else if (f_reg_rd) c = CMD_REG_RD;
        else if (f_pause)  c = CMD_PAUSE;
        else if (f_resume) c = CMD_RESUME;
        else               c = CMD_NONE;
        return c;
    endfunction

    function automatic logic mem_access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/db_timeout_counter.sv
// Cycle counter bounding how long the sequencer waits on the MCU.
// o_expired flags the LIMIT-th enabled cycle since the last clear.
module db_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/db_access_sequencer.sv
// Turns debug_controller commands into halt / access / reset sequences on the
// MCU side, with validation, a bounded wait and a sticky per-command error.
module db_access_sequencer
    import db_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RF_SIZE        = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_pause,
    input  logic        cmd_resume,
    input  logic        cmd_reset,
    input  logic        cmd_reg_rd,
    input  logic        cmd_reg_wr,
    input  logic        cmd_mem_rd,
    input  logic        cmd_mem_wr,
    input  logic [1:0]  cmd_mem_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_d_in,
    output logic        busy,
    output logic [31:0] rsp_d_rd,
    output logic        rsp_error,
    output logic        paused,
    output logic        mcu_halt,
    input  logic        mcu_halted,
    output logic        mcu_rst,
    output logic        acc_req,
    output logic        acc_we,
    output logic        acc_is_mem,
    output logic [1:0]  acc_size,
    output logic [31:0] acc_addr,
    output logic [31:0] acc_wdata,
    input  logic        acc_ack,
    input  logic [31:0] acc_rdata,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] RF_LIMIT = 32'(RF_SIZE);

    state_t      r_state;
    cmd_t        r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_d_in;
    logic [1:0]  r_size;
    logic        r_paused;
    logic        r_mcu_halt;
    logic        r_mcu_rst;
    logic        r_rsp_error;
    logic [31:0] r_rsp_d_rd;
    logic        r_acc_req;
    logic        r_acc_we;
    logic        r_acc_is_mem;
    logic [1:0]  r_acc_size;
    logic [31:0] r_acc_addr;
    logic [31:0] r_acc_wdata;

    cmd_t        w_cmd;
    logic        w_cmd_is_mem;
    logic        w_cmd_ok;
    cmd_t        w_ld_cmd;
    logic [31:0] w_ld_addr;
    logic [31:0] w_ld_data;
    logic [1:0]  w_ld_size;
    logic        w_ld_we;
    logic        w_ld_is_mem;
    logic        w_cnt_clear;
    logic        w_cnt_en;
    logic        w_expired;

    assign w_cmd = decode_cmd(cmd_reset, cmd_mem_wr, cmd_reg_wr, cmd_mem_rd,
                              cmd_reg_rd, cmd_pause, cmd_resume);
    assign w_cmd_is_mem = (w_cmd == CMD_MEM_WR) || (w_cmd == CMD_MEM_RD);
    assign w_cmd_ok     = w_cmd_is_mem ? mem_access_ok(cmd_mem_size, cmd_addr[1:0])
                                       : (cmd_addr < RF_LIMIT);

    // ACCESS is entered either straight from IDLE (MCU already halted) or from
    // HALT_WAIT, so the access fields come from the live command or the latch.
    assign w_ld_cmd    = (r_state == ST_IDLE) ? w_cmd        : r_cmd;
    assign w_ld_addr   = (r_state == ST_IDLE) ? cmd_addr     : r_addr;
    assign w_ld_data   = (r_state == ST_IDLE) ? cmd_d_in     : r_d_in;
    assign w_ld_size   = (r_state == ST_IDLE) ? cmd_mem_size : r_size;
    assign w_ld_we     = (w_ld_cmd == CMD_MEM_WR) || (w_ld_cmd == CMD_REG_WR);
    assign w_ld_is_mem = (w_ld_cmd == CMD_MEM_WR) || (w_ld_cmd == CMD_MEM_RD);

    assign w_cnt_clear = (r_state == ST_IDLE) || ((r_state == ST_HALT_WAIT) && mcu_halted);
    assign w_cnt_en    = (r_state == ST_HALT_WAIT) || (r_state == ST_ACCESS);

    db_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cmd        <= CMD_NONE;
            r_addr       <= '0;
            r_d_in       <= '0;
            r_size       <= '0;
            r_paused     <= 1'b0;
            r_mcu_halt   <= 1'b0;
            r_mcu_rst    <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_d_rd   <= '0;
            r_acc_req    <= 1'b0;
            r_acc_we     <= 1'b0;
            r_acc_is_mem <= 1'b0;
            r_acc_size   <= '0;
            r_acc_addr   <= '0;
            r_acc_wdata  <= '0;
        end else begin
            r_mcu_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd       <= w_cmd;
                        r_addr      <= cmd_addr;
                        r_d_in      <= cmd_d_in;
                        r_size      <= cmd_mem_size;
                        r_rsp_error <= 1'b0;
                        case (w_cmd)
                            CMD_RESET: begin
                                r_mcu_rst  <= 1'b1;
                                r_paused   <= 1'b0;
                                r_mcu_halt <= 1'b0;
                                r_state    <= ST_RESET_PULSE;
                            end
                            CMD_PAUSE: begin
                                r_paused   <= 1'b1;
                                r_mcu_halt <= 1'b1;
                                r_state    <= ST_HALT_WAIT;
                            end
                            CMD_RESUME: begin
                                r_paused   <= 1'b0;
                                r_mcu_halt <= 1'b0;
                            end
                            CMD_MEM_WR, CMD_REG_WR, CMD_MEM_RD, CMD_REG_RD: begin
                                if (!w_cmd_ok) begin
                                    r_rsp_error <= 1'b1;
                                end else if (!((w_cmd == CMD_REG_WR) && (cmd_addr == 32'd0))) begin
                                    r_mcu_halt <= 1'b1;
                                    if (mcu_halted) begin
                                        r_state      <= ST_ACCESS;
                                        r_acc_req    <= 1'b1;
                                        r_acc_we     <= w_ld_we;
                                        r_acc_is_mem <= w_ld_is_mem;
                                        r_acc_size   <= w_ld_is_mem ? w_ld_size : SIZE_WORD;
                                        r_acc_addr   <= w_ld_addr;
                                        r_acc_wdata  <= w_ld_data;
                                    end else begin
                                        r_state <= ST_HALT_WAIT;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_HALT_WAIT: begin
                    if (mcu_halted) begin
                        if (r_cmd == CMD_PAUSE) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state      <= ST_ACCESS;
                            r_acc_req    <= 1'b1;
                            r_acc_we     <= w_ld_we;
                            r_acc_is_mem <= w_ld_is_mem;
                            r_acc_size   <= w_ld_is_mem ? w_ld_size : SIZE_WORD;
                            r_acc_addr   <= w_ld_addr;
                            r_acc_wdata  <= w_ld_data;
                        end
                    end else if (w_expired) begin
                        r_rsp_error <= 1'b1;
                        r_mcu_halt  <= r_paused;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (acc_ack) begin
                        r_acc_req  <= 1'b0;
                        r_mcu_halt <= r_paused;
                        r_state    <= ST_IDLE;
                        if (!r_acc_we) begin
                            r_rsp_d_rd <= acc_rdata;
                        end
                    end else if (w_expired) begin
                        r_rsp_error <= 1'b1;
                        r_acc_req   <= 1'b0;
                        r_mcu_halt  <= r_paused;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RESET_PULSE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = cmd_valid || (r_state != ST_IDLE);
    assign rsp_d_rd   = r_rsp_d_rd;
    assign rsp_error  = r_rsp_error;
    assign paused     = r_paused;
    assign mcu_halt   = r_mcu_halt;
    assign mcu_rst    = r_mcu_rst;
    assign acc_req    = r_acc_req;
    assign acc_we     = r_acc_we;
    assign acc_is_mem = r_acc_is_mem;
    assign acc_size   = r_acc_size;
    assign acc_addr   = r_acc_addr;
    assign acc_wdata  = r_acc_wdata;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_db_access_sequencer.sv
// Directed bench for db_access_sequencer: a command-level model predicts the
// outcome of each command, a per-cycle monitor checks the outputs against it.
module tb_db_access_sequencer;
    import db_pkg::*;

    localparam int TO = 16;
    localparam int RF = 32;

    localparam logic [6:0] F_NONE   = 7'b0000000;
    localparam logic [6:0] F_RESET  = 7'b1000000;
    localparam logic [6:0] F_MEM_WR = 7'b0100000;
    localparam logic [6:0] F_REG_WR = 7'b0010000;
    localparam logic [6:0] F_MEM_RD = 7'b0001000;
    localparam logic [6:0] F_REG_RD = 7'b0000100;
    localparam logic [6:0] F_PAUSE  = 7'b0000010;
    localparam logic [6:0] F_RESUME = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_pause = 1'b0, cmd_resume = 1'b0, cmd_reset = 1'b0, cmd_reg_rd = 1'b0;
    logic        cmd_reg_wr = 1'b0, cmd_mem_rd = 1'b0, cmd_mem_wr = 1'b0;
    logic [1:0]  cmd_mem_size = 2'd0;
    logic [31:0] cmd_addr = 32'd0, cmd_d_in = 32'd0;
    logic        busy, rsp_error, paused, mcu_halt, mcu_rst;
    logic [31:0] rsp_d_rd;
    logic        mcu_halted = 1'b0;
    logic        acc_req, acc_we, acc_is_mem;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_ack = 1'b0;
    logic [31:0] acc_rdata = 32'd0;
    logic [1:0]  dbg_state;

    db_access_sequencer #(.TIMEOUT_CYCLES(TO), .RF_SIZE(RF)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_pause(cmd_pause),
        .cmd_resume(cmd_resume), .cmd_reset(cmd_reset), .cmd_reg_rd(cmd_reg_rd),
        .cmd_reg_wr(cmd_reg_wr), .cmd_mem_rd(cmd_mem_rd), .cmd_mem_wr(cmd_mem_wr),
        .cmd_mem_size(cmd_mem_size), .cmd_addr(cmd_addr), .cmd_d_in(cmd_d_in),
        .busy(busy), .rsp_d_rd(rsp_d_rd), .rsp_error(rsp_error), .paused(paused),
        .mcu_halt(mcu_halt), .mcu_halted(mcu_halted), .mcu_rst(mcu_rst),
        .acc_req(acc_req), .acc_we(acc_we), .acc_is_mem(acc_is_mem), .acc_size(acc_size),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_ack(acc_ack),
        .acc_rdata(acc_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // MCU and access-port responders
    int          halt_lat = 3;
    int          ack_lat = 2;
    bit          ack_en = 1'b1;
    logic [31:0] rd_val = 32'd0;
    bit          force_ack = 1'b0;
    logic [31:0] force_rdata = 32'd0;
    int          hcnt = 0;
    int          acnt = 0;

    always @(posedge clk) begin
        #1;
        if (mcu_halt) begin
            if (hcnt >= halt_lat) mcu_halted = 1'b1;
            else hcnt++;
        end else begin
            mcu_halted = 1'b0;
            hcnt = 0;
        end
        if (force_ack) begin
            acc_ack = 1'b1;
            acc_rdata = force_rdata;
        end else if (acc_req && ack_en) begin
            if (acnt >= ack_lat) begin
                acc_ack = 1'b1;
                acc_rdata = rd_val;
            end else begin
                acc_ack = 1'b0;
                acnt++;
            end
        end else begin
            acc_ack = 1'b0;
            acnt = 0;
        end
    end

    // Model state
    bit          m_paused = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_rd = 32'd0;
    bit          exp_acc_valid = 1'b0;
    bit          exp_acc_we = 1'b0, exp_acc_mem = 1'b0;
    logic [1:0]  exp_acc_size = 2'd0;
    logic [31:0] exp_acc_addr = 32'd0, exp_acc_wdata = 32'd0;
    bit          mon_en = 1'b0;
    bit          idle_chk = 1'b0;
    int          acc_cycles = 0, acc_hs = 0, rst_pulses = 0, halt_seen = 0;

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (cmd_valid) chk("busy_on_cmd_valid", 32'(busy), 32'd1);
            if (acc_req) begin
                acc_cycles++;
                chk("acc_req_expected", 32'(exp_acc_valid), 32'd1);
                chk("acc_ctrl", {28'd0, acc_we, acc_is_mem, acc_size},
                    {28'd0, exp_acc_we, exp_acc_mem, exp_acc_size});
                chk("acc_addr", acc_addr, exp_acc_addr);
                chk("acc_wdata", acc_wdata, exp_acc_wdata);
                chk("acc_while_halted", 32'({mcu_halt, mcu_halted}), 32'd3);
                if (acc_ack) acc_hs++;
            end
            if (mcu_rst) rst_pulses++;
            if (mcu_halt) halt_seen++;
            if (idle_chk) begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_rsp_error", 32'(rsp_error), 32'(m_err));
                chk("idle_paused", 32'(paused), 32'(m_paused));
                chk("idle_mcu_halt", 32'(mcu_halt), 32'(m_paused));
                chk("idle_rsp_d_rd", rsp_d_rd, m_rd);
                chk("idle_acc_req", 32'(acc_req), 32'd0);
            end
        end
    end

    task automatic drive_cmd(input logic [6:0] f, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        {cmd_reset, cmd_mem_wr, cmd_reg_wr, cmd_mem_rd, cmd_reg_rd, cmd_pause, cmd_resume} = f;
        cmd_mem_size = sz;
        cmd_addr = a;
        cmd_d_in = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        {cmd_reset, cmd_mem_wr, cmd_reg_wr, cmd_mem_rd, cmd_reg_rd, cmd_pause, cmd_resume} = 7'd0;
    endtask

    // Predict the outcome of one command, issue it, wait for it to finish and compare.
    task automatic do_cmd(input string nm, input logic [6:0] f, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input bit inject);
        int kind, bc, e_busy, e_pulses;
        bit is_acc, is_mem, is_wr, ok, e_err, e_access, n_paused;
        logic [31:0] n_rd;
        if (f[6])      kind = 1;
        else if (f[5]) kind = 2;
        else if (f[4]) kind = 3;
        else if (f[3]) kind = 4;
        else if (f[2]) kind = 5;
        else if (f[1]) kind = 6;
        else if (f[0]) kind = 7;
        else           kind = 0;
        is_acc = (kind >= 2) && (kind <= 5);
        is_mem = (kind == 2) || (kind == 4);
        is_wr  = (kind == 2) || (kind == 3);
        if (is_mem) ok = (sz != 2'd3) && !(sz == 2'd1 && a[0]) && !(sz == 2'd2 && a[1:0] != 2'd0);
        else        ok = (a < RF);
        e_err = 1'b0; e_access = 1'b0; e_busy = -1; e_pulses = 0;
        n_paused = m_paused; n_rd = m_rd;
        case (kind)
            0: e_busy = 0;
            1: begin n_paused = 1'b0; e_pulses = 1; e_busy = 1; end
            6: n_paused = 1'b1;
            7: begin n_paused = 1'b0; e_busy = 0; end
            default: ;
        endcase
        if (is_acc) begin
            if (!ok) begin
                e_err = 1'b1; e_busy = 0;
            end else if (kind == 3 && a == 32'd0) begin
                e_busy = 0;
            end else begin
                e_access = 1'b1;
                if (!ack_en) e_err = 1'b1;
                else if (!is_wr) n_rd = rd_val;
            end
        end
        exp_acc_valid = e_access;
        exp_acc_we = is_wr;
        exp_acc_mem = is_mem;
        exp_acc_size = is_mem ? sz : 2'd2;
        exp_acc_addr = a;
        exp_acc_wdata = d;
        idle_chk = 1'b0;
        acc_cycles = 0; acc_hs = 0; rst_pulses = 0; halt_seen = 0;
        drive_cmd(f, sz, a, d);
        if (inject) begin
            repeat (2) @(posedge clk);
            #1;
            cmd_valid = 1'b1; cmd_reset = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0; cmd_reset = 1'b0;
        end
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
        end
        chk({nm, "_done"}, 32'(bc < 200), 32'd1);
        m_paused = n_paused;
        m_rd = n_rd;
        m_err = e_err;
        chk({nm, "_rsp_error"}, 32'(rsp_error), 32'(m_err));
        chk({nm, "_paused"}, 32'(paused), 32'(m_paused));
        chk({nm, "_mcu_halt"}, 32'(mcu_halt), 32'(m_paused));
        chk({nm, "_rsp_d_rd"}, rsp_d_rd, m_rd);
        chk({nm, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        chk({nm, "_handshakes"}, 32'(acc_hs), 32'(e_access && ack_en));
        chk({nm, "_rst_pulses"}, 32'(rst_pulses), 32'(e_pulses));
        if (e_busy >= 0) chk({nm, "_busy_cycles"}, 32'(bc), 32'(e_busy));
        exp_acc_valid = 1'b0;
        idle_chk = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, and busy following cmd_valid while in reset
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outputs", {26'd0, mcu_halt, mcu_rst, acc_req, acc_we, acc_is_mem, paused}, 32'd0);
        chk("rst_acc_size", 32'(acc_size), 32'd0);
        chk("rst_acc_addr", acc_addr, 32'd0);
        chk("rst_acc_wdata", acc_wdata, 32'd0);
        chk("rst_rsp", {rsp_d_rd[30:0], rsp_error}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        cmd_valid = 1'b1; #1;
        chk("rst_busy_follows_cmd", 32'(busy), 32'd1);
        cmd_valid = 1'b0; #1;
        rst = 1'b0;
        mon_en = 1'b1;
        idle_chk = 1'b1;

        // Memory read from a running MCU
        halt_lat = 3; ack_lat = 2; rd_val = 32'hDEADBEEF;
        do_cmd("mem_rd_run", F_MEM_RD, SIZE_WORD, 32'h10, 32'h0, 1'b0);
        chk("lit_mem_rd_data", rsp_d_rd, 32'hDEADBEEF);
        chk("lit_mem_rd_halt_released", 32'({mcu_halt, paused}), 32'd0);

        // Misaligned word write is rejected without touching the MCU
        do_cmd("mem_wr_misaligned", F_MEM_WR, SIZE_WORD, 32'h2, 32'hCAFE, 1'b0);
        chk("lit_misaligned_err", 32'(rsp_error), 32'd1);
        chk("lit_misaligned_no_halt", 32'(halt_seen), 32'd0);
        do_cmd("size_invalid", F_MEM_RD, SIZE_INVALID, 32'h0, 32'h0, 1'b0);
        do_cmd("half_odd", F_MEM_WR, SIZE_HALF, 32'h101, 32'h55, 1'b0);
        do_cmd("no_flags", F_NONE, SIZE_BYTE, 32'h0, 32'h0, 1'b0);
        chk("lit_no_flags_clears_err", 32'(rsp_error), 32'd0);
        do_cmd("reg_rd_oob", F_REG_RD, SIZE_WORD, 32'd32, 32'h0, 1'b0);
        chk("lit_reg_oob_err", 32'(rsp_error), 32'd1);
        rd_val = 32'h31313131;
        do_cmd("reg_rd_last", F_REG_RD, SIZE_BYTE, 32'd31, 32'h0, 1'b0);
        chk("lit_reg_rd_last", rsp_d_rd, 32'h31313131);
        do_cmd("mem_wr_byte", F_MEM_WR, SIZE_BYTE, 32'h3, 32'hA5, 1'b0);
        chk("lit_write_keeps_rd", rsp_d_rd, 32'h31313131);
        rd_val = 32'h0000BEEF; ack_lat = 0;
        do_cmd("mem_rd_half", F_MEM_RD, SIZE_HALF, 32'h6, 32'h0, 1'b0);

        // Paused MCU: access keeps it halted, resume releases it
        ack_lat = 1;
        do_cmd("pause", F_PAUSE, SIZE_BYTE, 32'h0, 32'h0, 1'b0);
        chk("lit_pause_halt", 32'({mcu_halt, paused}), 32'd3);
        do_cmd("reg_wr_paused", F_REG_WR, SIZE_WORD, 32'd5, 32'h1234, 1'b0);
        chk("lit_reg_wr_keeps_halt", 32'(mcu_halt), 32'd1);
        do_cmd("reg_wr_zero", F_REG_WR, SIZE_WORD, 32'd0, 32'h9, 1'b0);
        do_cmd("resume", F_RESUME, SIZE_BYTE, 32'h0, 32'h0, 1'b0);
        chk("lit_resume_halt", 32'(mcu_halt), 32'd0);
        do_cmd("resume_idle", F_RESUME, SIZE_BYTE, 32'h0, 32'h0, 1'b0);

        // Reset wins over mem_wr, even while paused
        do_cmd("pause2", F_PAUSE, SIZE_BYTE, 32'h0, 32'h0, 1'b0);
        do_cmd("reset_mem_wr", F_RESET | F_MEM_WR, SIZE_WORD, 32'h40, 32'h1, 1'b0);
        chk("lit_reset_pulses", 32'(rst_pulses), 32'd1);
        chk("lit_reset_unpaused", 32'(paused), 32'd0);

        // A command arriving while busy is dropped
        halt_lat = 6; rd_val = 32'h600DF00D;
        do_cmd("busy_ignore", F_MEM_RD, SIZE_WORD, 32'h80, 32'h0, 1'b1);
        chk("lit_busy_ignore_data", rsp_d_rd, 32'h600DF00D);

        // Access timeout
        halt_lat = 3; ack_en = 1'b0;
        do_cmd("timeout", F_MEM_RD, SIZE_WORD, 32'h20, 32'h0, 1'b0);
        chk("lit_timeout_cycles", 32'(acc_cycles), 32'd16);
        chk("lit_timeout_err", 32'(rsp_error), 32'd1);
        ack_en = 1'b1;

        // Stray ack while idle must not update read data
        @(posedge clk); #1;
        force_ack = 1'b1; force_rdata = 32'hBAD0BAD0;
        repeat (3) @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_rd", rsp_d_rd, 32'h600DF00D);

        // Asynchronous reset in the middle of an access
        do_cmd("pause3", F_PAUSE, SIZE_BYTE, 32'h0, 32'h0, 1'b0);
        ack_en = 1'b0;
        idle_chk = 1'b0;
        exp_acc_valid = 1'b1; exp_acc_we = 1'b0; exp_acc_mem = 1'b1;
        exp_acc_size = SIZE_WORD; exp_acc_addr = 32'h44; exp_acc_wdata = 32'h0;
        rst_pulses = 0;
        drive_cmd(F_MEM_RD, SIZE_WORD, 32'h44, 32'h0);
        begin
            int w;
            w = 0;
            while (!acc_req && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("mid_rst_reached_access", 32'(acc_req), 32'd1);
        end
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("mid_rst_acc_req", 32'(acc_req), 32'd0);
        chk("mid_rst_mcu_halt", 32'(mcu_halt), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("mid_rst_paused", 32'(paused), 32'd0);
        chk("mid_rst_no_pulse", 32'({mcu_rst, 5'd0} | 32'(rst_pulses)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        exp_acc_valid = 1'b0;
        m_paused = 1'b0; m_err = 1'b0; m_rd = 32'd0;
        idle_chk = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
